// File: rtl/countdown_scan.sv
// MM:SS BCD countdown timer with a five-position multiplexed digit-code output
// (four digits plus a separator) for a downstream seven-segment decoder.
module countdown_scan #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] preset,
    output logic [3:0]  digit_code,
    output logic [4:0]  digit_sel,
    output logic        running,
    output logic        done,
    output logic        error
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         time_q, time_d, time_dec;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [SCAN_W-1:0]   scan_cnt_q;
    logic [2:0]          scan_idx_q;
    logic                tick_c;
    logic                scan_wrap_c;
    logic                preset_ok_c;
    logic [4:0]          sel_d;
    logic [3:0]          code_d;

    assign tick_c      = (tick_q == TICK_W'(TICK_DIV - 1));
    assign scan_wrap_c = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign preset_ok_c = (preset[15:12] <= 4'd9) && (preset[11:8] <= 4'd9) &&
                         (preset[7:4] <= 4'd5) && (preset[3:0] <= 4'd9);

    // One-second BCD decrement with borrow through sec_o -> sec_t -> min_o -> min_t
    always_comb begin
        time_dec = time_q;
        if (time_q[3:0] != 4'd0) begin
            time_dec[3:0] = time_q[3:0] - 4'd1;
        end else begin
            time_dec[3:0] = 4'd9;
            if (time_q[7:4] != 4'd0) begin
                time_dec[7:4] = time_q[7:4] - 4'd1;
            end else begin
                time_dec[7:4] = 4'd5;
                if (time_q[11:8] != 4'd0) begin
                    time_dec[11:8] = time_q[11:8] - 4'd1;
                end else begin
                    time_dec[11:8]  = 4'd9;
                    time_dec[15:12] = time_q[15:12] - 4'd1;
                end
            end
        end
    end

    // Next state, time and tick prescaler; load wins everywhere except RUN
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        tick_d  = tick_q;
        if (state_q != S_RUN && load) begin
            if (preset_ok_c) begin
                time_d  = preset;
                state_d = S_IDLE;
                tick_d  = '0;
            end else begin
                state_d = S_ERR;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (time_q != 16'h0000) begin
                            state_d = S_RUN;
                            tick_d  = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (tick_c) begin
                        tick_d = '0;
                        time_d = time_dec;
                        if (time_dec == 16'h0000) state_d = S_DONE;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (start && !pause) state_d = S_RUN;
                end
                default: ;
            endcase
        end
    end

    // Display payload for the current scan position
    always_comb begin
        sel_d  = 5'b10000 >> scan_idx_q;
        code_d = 4'd0;
        if (state_q == S_ERR) begin
            code_d = 4'd15;
        end else begin
            case (scan_idx_q)
                3'd0:    code_d = time_q[15:12];
                3'd1:    code_d = time_q[11:8];
                3'd2:    code_d = 4'd10;
                3'd3:    code_d = time_q[7:4];
                3'd4:    code_d = time_q[3:0];
                default: code_d = 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            time_q     <= 16'h0000;
            tick_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= 3'd0;
            digit_sel  <= 5'b10000;
            digit_code <= 4'd0;
            running    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            tick_q     <= tick_d;
            scan_cnt_q <= scan_wrap_c ? '0 : scan_cnt_q + SCAN_W'(1);
            if (scan_wrap_c) scan_idx_q <= (scan_idx_q == 3'd4) ? 3'd0 : scan_idx_q + 3'd1;
            digit_sel  <= sel_d;
            digit_code <= code_d;
            running    <= (state_d == S_RUN);
            done       <= (state_d == S_DONE);
            error      <= (state_d == S_ERR);
        end
    end

endmodule
